// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage selecting ALU, PC+4 or formatted load data for the register file
module writeback_stage #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] alu_res_i,
  input  logic [4:0]        rd_i,
  input  logic              regwren_i,
  input  logic [1:0]        wbsel_i,
  input  logic [2:0]        funct3_i,
  output logic              mem_req_o,
  output logic [DWIDTH-1:0] mem_addr_o,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic [4:0]        rd_o,
  output logic [DWIDTH-1:0] datawb_o,
  output logic              regwren_o,
  output logic              err_o
);
  typedef enum logic [1:0] {IDLE, LOAD_REQ, WAIT_MEM} state_t;
  state_t state;
  logic [4:0] ld_rd;
  logic ld_wr;
  logic [2:0] ld_f3;
  logic [1:0] ld_off;
  logic acc, ld_bad;
  logic [7:0] lb;
  logic [15:0] lh;
  logic [DWIDTH-1:0] ld_data;
  assign ready_o = state == IDLE;
  assign acc = valid_i && ready_o;
  always_comb begin
    ld_bad = funct3_i == 3'b011 || funct3_i[2:1] == 2'b11 ||
             (funct3_i[1:0] == 2'b01 && alu_res_i[0]) ||
             (funct3_i == 3'b010 && alu_res_i[1:0] != 2'b00);
    lb = mem_rdata_i[{ld_off, 3'b000} +: 8];
    lh = ld_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    // only LW has funct3[1] set among legal loads; funct3[2] selects zero extension
    ld_data = ld_f3[1] ? mem_rdata_i :
              ld_f3[0] ? {{16{~ld_f3[2] & lh[15]}}, lh} : {{24{~ld_f3[2] & lb[7]}}, lb};
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      rd_o       <= '0;
      datawb_o   <= '0;
      regwren_o  <= 1'b0;
      err_o      <= 1'b0;
      ld_rd      <= '0;
      ld_wr      <= 1'b0;
      ld_f3      <= '0;
      ld_off     <= '0;
    end else begin
      regwren_o <= 1'b0;
      err_o     <= 1'b0;
      mem_req_o <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          if (wbsel_i == 2'b01) begin
            if (ld_bad) err_o <= 1'b1;
            else begin
              state      <= LOAD_REQ;
              mem_req_o  <= 1'b1;
              mem_addr_o <= {alu_res_i[DWIDTH-1:2], 2'b00};
              ld_rd      <= rd_i;
              ld_wr      <= regwren_i;
              ld_f3      <= funct3_i;
              ld_off     <= alu_res_i[1:0];
            end
          end else if (wbsel_i != 2'b11 && regwren_i && rd_i != 5'd0) begin
            regwren_o <= 1'b1;
            rd_o      <= rd_i;
            datawb_o  <= wbsel_i[1] ? pc_i + DWIDTH'(4) : alu_res_i;
          end
        end
        LOAD_REQ: state <= WAIT_MEM;
        WAIT_MEM: if (mem_rvalid_i) begin
          state <= IDLE;
          if (ld_wr && ld_rd != 5'd0) begin
            regwren_o <= 1'b1;
            rd_o      <= ld_rd;
            datawb_o  <= ld_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: randomized scoreboard bench for writeback_stage against a behavioural model
module tb_writeback_stage;
  logic clk = 0, rst = 0;
  logic valid_i = 0, ready_o;
  logic [31:0] pc_i = 0, alu_res_i = 0, mem_addr_o, mem_rdata_i = 0, datawb_o;
  logic [4:0] rd_i = 0, rd_o;
  logic regwren_i = 0, regwren_o, err_o, mem_req_o, mem_rvalid_i = 0;
  logic [1:0] wbsel_i = 0;
  logic [2:0] funct3_i = 0;
  int checks = 0, errors = 0, err_pend = 0;
  bit resp_en = 0, man_rv = 0;
  logic [31:0] man_rd = 0;
  typedef struct {logic [4:0] rd; logic [31:0] d;} wr_t;
  typedef struct {logic [31:0] w; int dly;} rsp_t;
  wr_t wr_q[$];
  logic [31:0] req_q[$];
  rsp_t resp_q[$];

  writeback_stage #(.DWIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i),
    .alu_res_i(alu_res_i), .rd_i(rd_i), .regwren_i(regwren_i), .wbsel_i(wbsel_i),
    .funct3_i(funct3_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i), .rd_o(rd_o),
    .datawb_o(datawb_o), .regwren_o(regwren_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * off)) % 256;
    h = (w >> (16 * (off / 2))) % 65536;
    case (f3)
      3'd0: return b >= 128 ? b + 32'hFFFFFF00 : b;
      3'd4: return b;
      3'd1: return h >= 32768 ? h + 32'hFFFF0000 : h;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  task automatic send(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] rd,
                      input logic wr, input logic [1:0] ws, input logic [2:0] f3,
                      input logic [31:0] rdata, input int dly, input bit track);
    int n = 0;
    int sz;
    @(negedge clk);
    pc_i = pc; alu_res_i = alu; rd_i = rd; regwren_i = wr; wbsel_i = ws; funct3_i = f3;
    valid_i = 1;
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      checks++; errors++;
      $display("FAIL accept_timeout ready_o=%b required=1", ready_o);
      valid_i = 0;
      return;
    end
    @(posedge clk);
    if (ws == 2'b01) begin
      case (f3)
        3'd0, 3'd4: sz = 1;
        3'd1, 3'd5: sz = 2;
        3'd2: sz = 4;
        default: sz = 0;
      endcase
      if (sz == 0 || alu % sz != 0) err_pend++;
      else begin
        req_q.push_back(alu - alu % 4);
        if (track) begin
          resp_q.push_back('{rdata, dly});
          if (wr && rd != 0) wr_q.push_back('{rd, ref_load(rdata, alu % 4, f3)});
        end
      end
    end else if (ws != 2'b11 && wr && rd != 0)
      wr_q.push_back('{rd, ws == 2'b10 ? pc + 32'd4 : alu});
    #1 valid_i = 0;
  endtask

  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        mem_rvalid_i = man_rv;
        mem_rdata_i = man_rd;
      end else if (mem_req_o && resp_q.size() > 0) begin
        r = resp_q.pop_front();
        mem_rvalid_i = 0;
        repeat (r.dly + 1) @(negedge clk);
        mem_rvalid_i = 1;
        mem_rdata_i = r.w;
      end else begin
        // stray rvalid pulses land only in IDLE/LOAD_REQ and must be ignored
        mem_rvalid_i = !mem_req_o && $urandom_range(0, 3) == 0;
        mem_rdata_i = $urandom;
      end
    end
  end

  initial begin
    wr_t w;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (regwren_o) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write rd=%0d data=%h required=none", rd_o, datawb_o);
        end else begin
          w = wr_q.pop_front();
          if (rd_o !== w.rd || datawb_o !== w.d) begin
            errors++;
            $display("FAIL write rd=%0d data=%h required rd=%0d data=%h", rd_o, datawb_o, w.rd, w.d);
          end
        end
      end
      if (err_o) begin
        checks++;
        if (err_pend == 0) begin
          errors++;
          $display("FAIL unexpected_err err_o=1 required=0");
        end else err_pend--;
      end
      if (mem_req_o) begin
        checks++;
        if (req_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req addr=%h required=none", mem_addr_o);
        end else begin
          a = req_q.pop_front();
          if (mem_addr_o !== a) begin
            errors++;
            $display("FAIL req_addr actual=%h required=%h", mem_addr_o, a);
          end
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_regwren", {31'd0, regwren_o}, 0);
    chk("rst_err", {31'd0, err_o}, 0);
    chk("rst_req", {31'd0, mem_req_o}, 0);
    chk("rst_ready", {31'd0, ready_o}, 1);
    chk("rst_data", datawb_o, 0);
    chk("rst_rd", {27'd0, rd_o}, 0);
    chk("rst_addr", mem_addr_o, 0);
    rst = 1;
    // reset in the middle of WAIT_MEM drops the load
    send(0, 32'h80, 5'd3, 1, 2'b01, 3'd2, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 0; man_rv = 1; man_rd = 32'h12345678;
    repeat (2) @(negedge clk);
    #1;
    chk("midrst_ready", {31'd0, ready_o}, 1);
    chk("midrst_data", datawb_o, 0);
    chk("midrst_addr", mem_addr_o, 0);
    rst = 1;
    repeat (3) begin
      @(negedge clk);
      #1 chk("midrst_nowrite", {31'd0, regwren_o}, 0);
    end
    man_rv = 0;
    @(negedge clk);
    resp_en = 1;

    send(0, 32'h1234, 5'd5, 1, 2'b00, 3'd0, 0, 0, 1);
    fork
      send(32'h100, 32'hDEAD, 5'd6, 1, 2'b10, 3'd0, 0, 0, 1);
      begin
        @(negedge clk);
        #1 chk("b2b_first", {regwren_o, rd_o}, {1'b1, 5'd5});
        @(negedge clk);
        #1 chk("b2b_second", {regwren_o, rd_o}, {1'b1, 5'd6});
      end
    join

    send(0, 32'hFFFF, 5'd0, 1, 2'b00, 3'd0, 0, 0, 1);
    repeat (3) begin
      @(negedge clk);
      #1 chk("x0_nowrite", {31'd0, regwren_o}, 0);
    end

    send(0, 32'h23, 5'd10, 1, 2'b01, 3'd0, 32'h80FF7F01, 1, 1);
    send(0, 32'h21, 5'd11, 1, 2'b01, 3'd4, 32'h80FF7F01, 0, 1);
    send(0, 32'h22, 5'd12, 1, 2'b01, 3'd1, 32'h80FF7F01, 2, 1);
    send(0, 32'h20, 5'd13, 1, 2'b01, 3'd2, 32'h80FF7F01, 0, 1);
    send(0, 32'h22, 5'd14, 1, 2'b01, 3'd2, 0, 0, 1);
    send(0, 32'h20, 5'd15, 1, 2'b01, 3'd3, 0, 0, 1);

    send(0, 32'h40, 5'd7, 1, 2'b01, 3'd2, 32'hCAFEF00D, 5, 1);
    fork
      send(0, 32'h55, 5'd9, 1, 2'b00, 3'd0, 0, 0, 1);
      begin
        int lo = 0;
        bit rvp = 0;
        @(negedge clk);
        #1;
        while (!ready_o && lo < 50) begin
          lo++;
          rvp = mem_rvalid_i;
          @(negedge clk);
          #1;
        end
        chk("lat_wait_cycles", lo, 7);
        chk("lat_rvalid_before_write", {31'd0, rvp}, 1);
        chk("lat_write", {regwren_o, rd_o, datawb_o}, {1'b1, 5'd7, 32'hCAFEF00D});
        @(negedge clk);
        #1 chk("lat_next_accept", {regwren_o, rd_o}, {1'b1, 5'd9});
      end
    join

    repeat (300) begin
      logic [4:0] rd;
      rd = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send($urandom, $urandom, rd, 1'($urandom), 2'($urandom), 3'($urandom), $urandom,
           $urandom_range(0, 4), 1);
    end

    n = 0;
    while ((wr_q.size() != 0 || req_q.size() != 0 || resp_q.size() != 0 || err_pend != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("drain_writes", wr_q.size(), 0);
    chk("drain_reqs", req_q.size(), 0);
    chk("drain_resps", resp_q.size(), 0);
    chk("drain_errs", err_pend, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage, directly upstream of the register file.
- Accepts completed instructions from execute through a valid/ready handshake.
- Selects the writeback source: ALU result, PC+4, or load data. Load data comes from a variable-latency data-memory read, with byte/halfword extraction and sign/zero extension.
- Drives rd, write data and write enable into the register file as registered, single-cycle pulses.

Parameters:
- DWIDTH, 32: data and address width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- valid_i  in  1  upstream instruction valid
- ready_o  out  1  stage can accept an instruction
- pc_i  in  DWIDTH  instruction PC
- alu_res_i  in  DWIDTH  ALU result; also the load address
- rd_i  in  5  destination register
- regwren_i  in  1  instruction writes rd
- wbsel_i  in  2  writeback source: 00 ALU, 01 MEM, 10 PC+4, 11 reserved
- funct3_i  in  3  load type
- mem_req_o  out  1  data-memory read request, one-cycle pulse
- mem_addr_o  out  DWIDTH  word-aligned read address
- mem_rdata_i  in  DWIDTH  read data
- mem_rvalid_i  in  1  read data valid
- rd_o  out  5  register-file rd
- datawb_o  out  DWIDTH  register-file write data
- regwren_o  out  1  register-file write enable, one-cycle pulse
- err_o  out  1  misaligned or illegal load, one-cycle pulse

Behaviour:
- Reset: sampled on the clk edge while rst=0.
  - State returns to IDLE.
  - All outputs go to 0.
  - Any in-flight load is dropped; a later mem_rvalid_i is ignored.
- States:
  - IDLE: ready_o=1.
  - LOAD_REQ: ready_o=0, mem_req_o=1.
  - WAIT_MEM: ready_o=0.
- Handshake: a transfer occurs on the edge where valid_i=1 and ready_o=1. All inputs are captured on that edge.
- Non-load transfer (wbsel 00/10), accepted at edge E:
  - In the cycle after E: regwren_o = regwren_i AND (rd_i≠0), rd_o=rd_i.
  - datawb_o = alu_res_i for 00, or pc_i+4 (mod 2^32) for 10.
  - State stays IDLE, so throughput is 1 per cycle.
- wbsel 11: accepted; no write, no err_o.
- Load transfer (wbsel 01), accepted at edge E:
  - If misaligned or funct3 is illegal: no memory request, err_o=1 in the cycle after E, regwren_o=0, state stays IDLE.
    - Misaligned: LH/LHU with addr[0]=1, or LW with addr[1:0]≠0.
    - Illegal funct3: 011, 110, 111.
  - Otherwise, in the cycle after E: LOAD_REQ, with mem_req_o=1 and mem_addr_o={addr[31:2],2'b00}.
  - The next edge moves the state to WAIT_MEM.
  - WAIT_MEM stays until mem_rvalid_i=1 is sampled. The data is formatted and registered on that edge.
    - In the following cycle: regwren_o = regwren_i AND (rd≠0), rd_o and datawb_o valid.
    - The state returns to IDLE on that same edge.
  - mem_rvalid_i during IDLE or LOAD_REQ is ignored.
  - Minimum load latency: accept at E, request in E+1, rvalid sampled at end of E+2, write in E+3.
- Load formatting, using byte offset addr[1:0]:
  - LB (000): sign-extend the selected byte.
  - LBU (100): zero-extend the selected byte.
  - LH (001): sign-extend the halfword selected by addr[1].
  - LHU (101): zero-extend the halfword selected by addr[1].
  - LW (010): full word.
- Output holding:
  - rd_o and datawb_o hold their last values when regwren_o=0.
  - regwren_o, err_o and mem_req_o are never high for two consecutive cycles from the same instruction.
- ready_o is combinational from state only and does not depend on valid_i.

Test Plan:
- Reset: hold rst=0 for 2 cycles mid-WAIT_MEM, then release and drive mem_rvalid_i=1 -> all outputs 0, ready_o=1, no write occurs.
- Back-to-back ALU ops: two transfers in consecutive cycles.
  - Stimulus: (rd=5, alu=0x1234), then (rd=6, wbsel=10, pc=0x100).
  - Response: regwren_o pulses in two consecutive cycles with (5, 0x1234) then (6, 0x104).
- Writes to x0: rd=0, regwren_i=1, alu=0xFFFF -> regwren_o stays 0.
- Load formatting: mem_rdata=0x80FF7F01 at addr 0x20+k.
  - LB at k=3 -> 0xFFFFFF80.
  - LBU at k=1 -> 0x0000007F.
  - LH at k=2 -> 0xFFFF80FF.
  - LW at k=0 -> 0x80FF7F01.
  - Each load: mem_addr_o=0x20, mem_req_o pulses once.
- Variable latency: LW, then mem_rvalid_i delayed 5 cycles -> ready_o=0 throughout the wait; the write occurs exactly 1 cycle after rvalid; a valid_i held high upstream is accepted the cycle after the write begins.
- Errors: LW at addr 0x22 -> err_o pulses, no mem_req_o, no write. funct3=011 -> err_o pulses.
